// File: rtl/image_line_ctrl_pkg.sv
// Shared constants, read FSM encoding and buffer-index helper for the
// 3x3 window line-buffer controller.
package image_line_ctrl_pkg;

  localparam int LINE_W = 512;
  localparam int NUM_LB = 4;
  localparam int DATA_W = 8;
  localparam int ROW_W  = 3 * DATA_W;
  localparam int WIN_W  = 9 * DATA_W;
  localparam int PTR_W  = $clog2(LINE_W);
  localparam int CNT_W  = $clog2(NUM_LB * LINE_W + 1);
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  // Buffer indices wrap naturally at NUM_LB = 4.
  function automatic logic [SEL_W-1:0] idx_inc(input logic [SEL_W-1:0] idx,
                                               input logic [SEL_W-1:0] step);
    return idx + step;
  endfunction

endpackage

// File: rtl/image_line_ctrl_lbuf.sv
// Single pixel line buffer: sequential write, 3-pixel combinational read
// window with addresses wrapping inside the line.
module image_line_ctrl_lbuf
  import image_line_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  output logic [ROW_W-1:0]  o_row
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_TWO = PTR_W'(2);

  logic [DATA_W-1:0] r_mem [LINE_W];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  w_rd_ptr1;
  logic [PTR_W-1:0]  w_rd_ptr2;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  assign w_rd_ptr1 = r_rd_ptr + PTR_ONE;
  assign w_rd_ptr2 = r_rd_ptr + PTR_TWO;
  assign o_row     = {r_mem[r_rd_ptr], r_mem[w_rd_ptr1], r_mem[w_rd_ptr2]};

endmodule

// File: rtl/image_line_ctrl.sv
// Line-buffer sequencer for the 3x3 convolution stage: rotates writes over
// four buffers and streams 3x3 windows once three lines are stored.
module image_line_ctrl
  import image_line_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_pixel_data,
  input  logic              i_pixel_data_valid,
  output logic [WIN_W-1:0]  o_pixel_data,
  output logic              o_pixel_data_valid,
  output logic              o_intr,
  output logic              o_overflow
);

  localparam logic [CNT_W-1:0] RD_THRESH = CNT_W'(3 * LINE_W);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_LB * LINE_W);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] LAST_COL  = PTR_W'(LINE_W - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  rd_state_t         r_state;
  logic [SEL_W-1:0]  r_wr_sel;
  logic [SEL_W-1:0]  r_rd_sel;
  logic [PTR_W-1:0]  r_wr_cnt;
  logic [PTR_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_total_cnt;

  logic              w_rd_en;
  logic [SEL_W-1:0]  w_mid_sel;
  logic [SEL_W-1:0]  w_bot_sel;
  logic [NUM_LB-1:0] w_buf_wr;
  logic [NUM_LB-1:0] w_buf_rd;
  logic [ROW_W-1:0]  w_rows [NUM_LB];

  assign w_rd_en   = (r_state == READ);
  assign w_mid_sel = idx_inc(r_rd_sel, 2'd1);
  assign w_bot_sel = idx_inc(r_rd_sel, 2'd2);

  // The fourth buffer (rd_sel+3) is left alone so it can take the next line.
  always_comb begin
    w_buf_wr            = '0;
    w_buf_rd            = '0;
    w_buf_wr[r_wr_sel]  = i_pixel_data_valid;
    w_buf_rd[r_rd_sel]  = w_rd_en;
    w_buf_rd[w_mid_sel] = w_rd_en;
    w_buf_rd[w_bot_sel] = w_rd_en;
  end

  for (genvar g = 0; g < NUM_LB; g++) begin : g_lb
    image_line_ctrl_lbuf u_lbuf (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_data  (i_pixel_data),
      .i_wr_en (w_buf_wr[g]),
      .i_rd_en (w_buf_rd[g]),
      .o_row   (w_rows[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_sel <= '0;
      r_wr_cnt <= '0;
    end else if (i_pixel_data_valid) begin
      if (r_wr_cnt == LAST_COL) begin
        r_wr_cnt <= '0;
        r_wr_sel <= idx_inc(r_wr_sel, 2'd1);
      end else begin
        r_wr_cnt <= r_wr_cnt + PTR_ONE;
      end
    end
  end

  // A full bank still accepts the pixel; the error is only flagged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_total_cnt <= '0;
      o_overflow  <= 1'b0;
    end else begin
      case ({i_pixel_data_valid, w_rd_en})
        2'b10:   r_total_cnt <= r_total_cnt + CNT_ONE;
        2'b01:   r_total_cnt <= r_total_cnt - CNT_ONE;
        default: ;
      endcase
      if (i_pixel_data_valid && !w_rd_en && (r_total_cnt == FULL_CNT))
        o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_rd_sel <= '0;
      r_rd_cnt <= '0;
      o_intr   <= 1'b0;
    end else begin
      o_intr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_total_cnt >= RD_THRESH) r_state <= READ;
        end
        READ: begin
          if (r_rd_cnt == LAST_COL) begin
            r_rd_cnt <= '0;
            r_rd_sel <= idx_inc(r_rd_sel, 2'd1);
            o_intr   <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_rd_cnt <= r_rd_cnt + PTR_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_pixel_data_valid = w_rd_en;
  assign o_pixel_data       = {w_rows[r_rd_sel], w_rows[w_mid_sel], w_rows[w_bot_sel]};

endmodule

// File: tb/tb_image_line_ctrl.sv
// Scoreboard bench for image_line_ctrl: windows are predicted from the list
// of written pixels and compared by an independent monitor.
`timescale 1ns/1ps
module tb_image_line_ctrl;
  import image_line_ctrl_pkg::*;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] pix_in;
  logic              pix_vld;
  logic [WIN_W-1:0]  win;
  logic              win_vld;
  logic              intr;
  logic              ovf;

  image_line_ctrl dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_pixel_data       (pix_in),
    .i_pixel_data_valid (pix_vld),
    .o_pixel_data       (win),
    .o_pixel_data_valid (win_vld),
    .o_intr             (intr),
    .o_overflow         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]       pix[$];
  logic [WIN_W-1:0] exp_q[$];
  bit               sb_en = 1'b1;

  int grp       = 0;
  int vcount    = 0;
  int intr_cnt  = 0;
  logic prev_v  = 1'b0;

  task automatic chk(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] row_of(input int line, input int c);
    int b;
    b = line * LINE_W;
    return {pix[b + (c % LINE_W)], pix[b + ((c + 1) % LINE_W)], pix[b + ((c + 2) % LINE_W)]};
  endfunction

  // Completing line n+2 makes group n (lines n, n+1, n+2) readable.
  task automatic push_pixel(input logic [7:0] d);
    int g;
    pix.push_back(d);
    if (sb_en && (pix.size() % LINE_W == 0) && (pix.size() >= 3 * LINE_W)) begin
      g = pix.size() / LINE_W - 3;
      for (int c = 0; c < LINE_W; c++)
        exp_q.push_back({row_of(g, c), row_of(g + 1, c), row_of(g + 2, c)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [7:0] d);
    pix_in  = d;
    pix_vld = 1'b1;
    @(posedge clk); #1;
    pix_vld = 1'b0;
    push_pixel(d);
  endtask

  task automatic stream_lines(input int n);
    for (int i = 0; i < n * LINE_W; i++) begin
      while ($urandom_range(0, 3) == 0) idle(1);
      wr(8'($urandom_range(0, 255)));
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    pix_vld = 1'b0;
    idle(2);
    exp_q.delete();
    pix.delete();
    sb_en = 1'b1;
    rst   = 1'b0;
  endtask

  // Entered 1 ns after the edge that stores the 1536th pixel: the count is
  // visible this cycle, the registered decision starts the read one cycle later.
  task automatic fill_timing();
    int  run;
    bit  early_intr;
    @(negedge clk);
    chk("valid_before_start", WIN_W'(win_vld), WIN_W'(0));
    @(negedge clk);
    chk("valid_rise", WIN_W'(win_vld), WIN_W'(1));
    run = 0;
    early_intr = 1'b0;
    while (win_vld && run < 600) begin
      run++;
      if (intr) early_intr = 1'b1;
      @(negedge clk);
    end
    chk("valid_run_len", WIN_W'(run), WIN_W'(LINE_W));
    chk("intr_during_read", WIN_W'(early_intr), WIN_W'(0));
    chk("intr_after_read", WIN_W'(intr), WIN_W'(1));
    @(negedge clk);
    chk("intr_one_cycle", WIN_W'(intr), WIN_W'(0));
  endtask

  task automatic fill_and_check(input bit cont);
    for (int i = 0; i < 3 * LINE_W; i++) wr(8'(i));
    fork
      begin
        if (cont) stream_lines(4);
        else idle(1);
      end
      fill_timing();
    join
  endtask

  task automatic wait_intr(input int n, input int budget);
    int k;
    k = 0;
    while (intr_cnt < n && k < budget) begin idle(1); k++; end
    idle(4);
    chk("intr_count", WIN_W'(intr_cnt), WIN_W'(n));
    chk("scoreboard_drained", WIN_W'(exp_q.size()), WIN_W'(0));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        grp = 0; vcount = 0; intr_cnt = 0; prev_v = 1'b0;
      end else begin
        if (intr) intr_cnt++;
        if (win_vld) begin
          if (!prev_v) begin
            chk("rd_sel", WIN_W'(dut.r_rd_sel), WIN_W'(grp % 4));
            grp++;
          end
          vcount++;
          if (sb_en) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL window: valid with no expected window, got %h", win);
            end else begin
              chk("window", win, exp_q.pop_front());
            end
          end
        end
        prev_v = win_vld;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; pix_in = '0; pix_vld = 1'b0;
    do_reset();
    chk("rst_valid",    WIN_W'(win_vld), WIN_W'(0));
    chk("rst_intr",     WIN_W'(intr), WIN_W'(0));
    chk("rst_overflow", WIN_W'(ovf), WIN_W'(0));
    chk("rst_total",    WIN_W'(dut.r_total_cnt), WIN_W'(0));

    // Fill, then keep streaming four lines with random gaps.
    fill_and_check(1'b1);
    wait_intr(5, 4000);
    chk("rot_groups",   WIN_W'(grp), WIN_W'(5));
    chk("rot_total",    WIN_W'(dut.r_total_cnt), WIN_W'(2 * LINE_W));
    chk("rot_overflow", WIN_W'(ovf), WIN_W'(0));

    // Idle input mid-line, then reset in the middle of the first read.
    do_reset();
    for (int i = 0; i < 1000; i++) wr(8'(i));
    chk("wr_cnt_before_pause", WIN_W'(dut.r_wr_cnt), WIN_W'(1000 - LINE_W));
    k = 0;
    for (int i = 0; i < 50; i++) begin
      idle(1);
      if (win_vld) k++;
    end
    chk("wr_cnt_after_pause", WIN_W'(dut.r_wr_cnt), WIN_W'(1000 - LINE_W));
    chk("no_early_read", WIN_W'(k), WIN_W'(0));
    for (int i = 1000; i < 3 * LINE_W; i++) wr(8'(i));
    k = 0;
    while (vcount < 100 && k < 200) begin idle(1); k++; end
    chk("valid_cycles_before_rst", WIN_W'(vcount), WIN_W'(100));
    chk("rd_cnt_at_rst", WIN_W'(dut.r_rd_cnt), WIN_W'(100));
    rst = 1'b1;
    idle(1);
    chk("midrst_valid",    WIN_W'(win_vld), WIN_W'(0));
    chk("midrst_intr",     WIN_W'(intr), WIN_W'(0));
    chk("midrst_overflow", WIN_W'(ovf), WIN_W'(0));
    do_reset();
    fill_and_check(1'b0);
    wait_intr(1, 200);
    chk("refill_total", WIN_W'(dut.r_total_cnt), WIN_W'(2 * LINE_W));

    // Overflow: reads held off so the bank fills completely.
    do_reset();
    force dut.r_state = IDLE;
    sb_en = 1'b0;
    for (int i = 0; i < NUM_LB * LINE_W; i++) wr(8'(i));
    @(negedge clk);
    chk("full_total",      WIN_W'(dut.r_total_cnt), WIN_W'(NUM_LB * LINE_W));
    chk("full_no_ovf",     WIN_W'(ovf), WIN_W'(0));
    chk("full_no_valid",   WIN_W'(win_vld), WIN_W'(0));
    wr(8'hAA);
    @(negedge clk);
    chk("ovf_set", WIN_W'(ovf), WIN_W'(1));
    release dut.r_state;
    idle(600);
    chk("ovf_sticky", WIN_W'(ovf), WIN_W'(1));
    do_reset();
    chk("ovf_cleared", WIN_W'(ovf), WIN_W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
